// File: rtl/pwm_adc_decoder.sv
// pwm_adc_decoder: recovers a WIDTH-bit code from the duty cycle of a
// single-bit PWM stream. Each frame is 2^WIDTH clocks long. The line is high
// for (code+1) clocks starting at frame position 0 and low for the rest.
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous, active-low reset
//   pwm_in  PWM line from the DAC (asynchronous to nothing, but synchronized)
//   data    last decoded code, held between updates
//   valid   one-cycle pulse when data updates
//   locked  high while frame-aligned
//   err     one-cycle pulse on a framing violation
module pwm_adc_decoder #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             locked,
  output logic             err
);

  localparam int unsigned HiW = WIDTH + 1;
  localparam logic [WIDTH-1:0] PosLast = '1;

  typedef enum logic {
    HUNT,
    MEASURE
  } stateE;

  stateE              state, stateNext;
  logic [SYNC_STAGES-1:0] syncReg;
  logic               sPrev;
  logic               s;
  logic               riseEdge;
  logic [WIDTH-1:0]   pos, posNext;
  logic [HiW-1:0]     hi, hiNext;
  logic [HiW-1:0]     total;
  logic [WIDTH-1:0]   dataNext;
  logic               validNext;
  logic               errNext;

  // Synchronized line sample and its rising edge.
  assign s        = syncReg[SYNC_STAGES-1];
  assign riseEdge = s & ~sPrev;

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syncReg <= '0;
      sPrev   <= 1'b0;
      state   <= HUNT;
      pos     <= '0;
      hi      <= '0;
      data    <= '0;
      valid   <= 1'b0;
      locked  <= 1'b0;
      err     <= 1'b0;
    end else begin
      syncReg <= {syncReg[SYNC_STAGES-2:0], pwm_in};
      sPrev   <= s;
      state   <= stateNext;
      pos     <= posNext;
      hi      <= hiNext;
      data    <= dataNext;
      valid   <= validNext;
      locked  <= (stateNext == MEASURE);
      err     <= errNext;
    end
  end

  // Next-state, window accounting and framing checks.
  always_comb begin
    stateNext = state;
    posNext   = pos;
    hiNext    = hi;
    dataNext  = data;
    validNext = 1'b0;
    errNext   = 1'b0;
    // Count including the final sample of the window; needs WIDTH+1 bits.
    total     = hi + HiW'(s);

    case (state)
      HUNT: begin
        // The edge cycle itself is frame position 0.
        if (riseEdge) begin
          stateNext = MEASURE;
          posNext   = WIDTH'(1);
          hiNext    = HiW'(1);
        end
      end

      MEASURE: begin
        posNext = pos + WIDTH'(1);
        hiNext  = total;
        if (riseEdge && (pos != '0)) begin
          // Edge away from position 0: realign to it and drop the partial window.
          errNext = 1'b1;
          posNext = WIDTH'(1);
          hiNext  = HiW'(1);
        end else if ((pos == '0) && !s) begin
          // A frame must start high; a full-scale code stays high with no edge.
          errNext   = 1'b1;
          stateNext = HUNT;
          posNext   = '0;
          hiNext    = '0;
        end else if (pos == PosLast) begin
          hiNext = '0;
          if (total == '0) begin
            errNext   = 1'b1;
            stateNext = HUNT;
            posNext   = '0;
          end else begin
            validNext = 1'b1;
            dataNext  = WIDTH'(total - HiW'(1));
          end
        end
      end

      default: begin
        stateNext = HUNT;
        posNext   = '0;
        hiNext    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_adc_decoder.sv
// Bench for pwm_adc_decoder: drives PWM frames and compares every cycle
// against a frame-level model of the decoder, plus literal expectations.
module tb_pwm_adc_decoder;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SYNC  = 2;
  localparam int FRAME = 256;
  localparam int HIST  = 8192;
  localparam int NSEQ  = 17;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pwm_in = 1'b0;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             locked;
  logic             err;

  pwm_adc_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .data(data), .valid(valid), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  // line[t] = level the DUT's first sync flop captures at posedge t
  // (forced to 0 where a reset wipes it out of the synchronizer).
  bit   line [0:HIST-1];
  int   cyc = 0;
  int   nChecks = 0;
  int   nPass = 0;

  // Model state: frame-level view of alignment.
  bit         mLocked = 1'b0;
  int         mStart = 0;
  logic [7:0] mData = '0;
  bit         mValid = 1'b0;
  bit         mErr = 1'b0;

  // Observations of the DUT.
  logic [7:0] validQ [$];
  int   errCount = 0;
  int   firstLockCyc = -1;
  bit   watchValid = 1'b0;
  int   firstValidAfter = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s @cycle %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
  endtask

  // Sample value the decoder acts on at posedge t.
  function automatic bit sampleAt(input int t);
    int i;
    i = t - int'(SYNC);
    if (i < 0 || i >= HIST) return 1'b0;
    return line[i];
  endfunction

  function automatic int windowOnes(input int t);
    int sum;
    sum = 0;
    for (int k = t - FRAME + 1; k <= t; k++) sum += int'(sampleAt(k));
    return sum;
  endfunction

  // Expected outputs after posedge cyc.
  task automatic modelStep();
    bit x, rising;
    int p, total;
    mValid = 1'b0;
    mErr   = 1'b0;
    if (!rst) begin
      mLocked = 1'b0;
      mData   = '0;
    end else begin
      x      = sampleAt(cyc);
      rising = x && !sampleAt(cyc - 1);
      if (!mLocked) begin
        if (rising) begin
          mLocked = 1'b1;
          mStart  = cyc;
        end
      end else begin
        p = (cyc - mStart) % FRAME;
        if (rising && p != 0) begin
          mErr   = 1'b1;
          mStart = cyc;
        end else if (p == 0 && !x) begin
          mErr    = 1'b1;
          mLocked = 1'b0;
        end else if (p == FRAME - 1) begin
          total = windowOnes(cyc);
          if (total == 0) begin
            mErr    = 1'b1;
            mLocked = 1'b0;
          end else begin
            mValid = 1'b1;
            mData  = 8'(total - 1);
          end
        end
      end
    end
  endtask

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      modelStep();
      #1;
      check("cycle{data,valid,err,locked}", {data, valid, err, locked},
            {mData, mValid, mErr, mLocked});
      if (valid) validQ.push_back(data);
      if (err) errCount++;
      if (locked && firstLockCyc < 0) firstLockCyc = cyc;
      if (valid && watchValid && firstValidAfter < 0) firstValidAfter = cyc;
    end
  end

  task automatic drive(input bit v, output int idx);
    @(negedge clk);
    pwm_in = v;
    idx = cyc + 1;
    if (idx < HIST) line[idx] = rst ? v : 1'b0;
  endtask

  task automatic asyncReset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int k = cyc - int'(SYNC); k <= cyc; k++) if (k >= 0 && k < HIST) line[k] = 1'b0;
    #1;
    check("async_reset_outputs", {data, valid, err, locked}, 0);
  endtask

  task automatic frame(input int code, input int rstPos, output int startIdx);
    int idx;
    startIdx = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (rstPos >= 0 && i == rstPos + 10) rst = 1'b1;
      drive(i <= code, idx);
      if (i == 0) startIdx = idx;
      if (i == rstPos) asyncReset();
    end
  endtask

  initial begin
    int idx, e0, eR;
    logic [7:0] expSeq [NSEQ];
    expSeq = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'hFF, 8'hFF,
               8'h40, 8'h40, 8'h40, 8'h20, 8'h20, 8'h20, 8'h01, 8'h7F, 8'hFE};

    repeat (3) drive(1'b0, idx);
    check("reset_state", {data, valid, err, locked}, 0);
    rst = 1'b1;
    repeat (4) drive(1'b0, idx);

    // Lock and steady code.
    frame(8'h80, -1, e0);
    repeat (3) frame(8'h80, -1, idx);
    check("lock_latency", 32'(firstLockCyc - e0), 32'(SYNC));
    check("no_err_steady", errCount, 0);

    // Extremes, switching at frame boundaries.
    repeat (2) frame(8'h00, -1, idx);
    repeat (2) frame(8'hFF, -1, idx);
    check("locked_through_ff", locked, 1);
    check("no_err_extremes", errCount, 0);

    // Glitch at position 150 of a 0x40 frame.
    frame(8'h40, -1, idx);
    for (int i = 0; i < FRAME; i++) drive((i <= 8'h40) || (i == 150), idx);
    repeat (2) frame(8'h40, -1, idx);
    check("glitch_errs", errCount, 2);

    // Dead line.
    repeat (300) drive(1'b0, idx);
    check("dead_unlocked", locked, 0);
    check("dead_data_held", data, 8'h40);
    check("dead_err", errCount, 3);
    repeat (2) frame(8'h20, -1, idx);

    // Reset mid-window, then relock.
    frame(8'h20, 100, idx);
    check("post_reset_data", data, 0);
    watchValid = 1'b1;
    frame(8'h20, -1, eR);

    // Code sweep plus a short tail so the last window publishes.
    frame(8'h01, -1, idx);
    frame(8'h7F, -1, idx);
    frame(8'hFE, -1, idx);
    repeat (8) drive(1'b1, idx);

    check("relock_delay_ge_frame", 32'(firstValidAfter >= 0 && (firstValidAfter - eR) >= FRAME), 1);
    check("final_data", data, 8'hFE);
    check("total_errs", errCount, 3);
    check("valid_count", validQ.size(), NSEQ);
    for (int i = 0; i < NSEQ; i++) begin
      if (i < validQ.size()) check($sformatf("valid_seq[%0d]", i), validQ[i], expSeq[i]);
      else check($sformatf("valid_seq[%0d]_missing", i), 32'hFFFF_FFFF, expSeq[i]);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
